bcd_display_driver: RTL
=======================

Name: bcd_display_driver

Overview:
- Downstream consumer of the 6-bit signed multiplier: takes its 12-bit product magnitude `c` and sign `neg` and drives five seven-segment digits HEX_0..HEX_4.
- Converts binary to BCD sequentially with shift-add-3 (double dabble), one bit per clock.
- Registers the result so the displays stay stable between conversions.
- HEX_0..HEX_3 show decimal digits, units to thousands; HEX_4 shows the minus sign.

Parameters:
- BLANK_LEADING, 1, 1 = blank leading zero digits (HEX_0 is never blanked); 0 = show all four digits.
- SEG_ACTIVE_LOW, 1, 1 = segment on when bit is 0; 0 = inverted polarity on all HEX outputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  start pulse; sampled only in IDLE.
- mag  in  12  unsigned magnitude (multiplier `c`), range 0..4095.
- neg  in  1  sign of result (multiplier `neg`).
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the displays update.
- HEX_0..HEX_4  out  7 each  segment bits {g,f,e,d,c,b,a}, bit0 = a.

Behaviour:
- Reset: one clock, asynchronous and active-high. rst=1 clears everything immediately, without waiting for a clock edge.
  - state=IDLE, busy=0, done=0.
  - HEX_0 shows "0"; HEX_1..HEX_4 are blank (all segments off).
  - Shift register, bit counter and captured sign are cleared.
- FSM has three states: IDLE, CONV, SHOW.
- IDLE:
  - On an edge with load=1, capture mag into the shift register and neg into the sign register.
  - Clear the 16-bit BCD scratch and counter; go to CONV with busy=1.
- CONV: each edge performs one iteration.
  - First, each BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - After the 12th iteration (counter = 11), go to SHOW.
- SHOW (one cycle):
  - Decode the BCD nibbles into the HEX registers.
  - Set HEX_4 and pulse done=1; busy=0; return to IDLE.
- Latency: if load is sampled at edge E0, iterations occur at E1..E12. HEX outputs and done=1 become valid after E13 and done drops after E14.
- A new load may be accepted at E14 at the earliest.
- load while busy (CONV or SHOW) is ignored, not queued.
- HEX outputs hold their last value until the next SHOW. A load of a new value does not disturb the displayed result during conversion.
- Inputs mag and neg are sampled only at the accepting edge; later changes have no effect on the running conversion.
- Digit decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Leading blanking (BLANK_LEADING=1):
  - HEX_3 blank if thousands=0.
  - HEX_2 blank if thousands=0 and hundreds=0.
  - HEX_1 blank if the upper three digits are all 0.
  - HEX_0 always shown.
- Sign:
  - HEX_4 = "-" (0111111) when captured neg=1 and mag≠0.
  - Otherwise HEX_4 is blank; negative zero displays as "0" with no sign.
- SEG_ACTIVE_LOW=0 inverts every HEX bit, including blank.
- Reset mid-conversion: the conversion is aborted, the reset display is shown, and no done pulse is produced.
- Maximum value 4095 fits in 4 digits; there is no overflow case.

Test Plan:
1. Reset, then mag=63, neg=1, load pulse
   -> busy high 13 cycles; done at E13.
   -> HEX_0=0110000 ("3"), HEX_1=0000010 ("6"), HEX_2=HEX_3=1111111, HEX_4=0111111.
2. mag=200, neg=0, load
   -> HEX_0=1000000, HEX_1=1000000, HEX_2=0100100 ("2"), HEX_3=1111111, HEX_4=1111111.
3. mag=4095, neg=0, load
   -> HEX_3="4" 0011001, HEX_2="0" 1000000, HEX_1="9" 0010000, HEX_0="5" 0010010.
   -> Repeat with mag=0, neg=1: HEX_0=1000000, all others blank.
4. Load 63, then load 200 again at E5 while busy, with mag changed to 999 at E3
   -> second load ignored; exactly one done pulse; display shows 63.
5. Load 1024, assert rst at E6 for 2 cycles
   -> immediately HEX_0="0", others blank, busy=0; no done pulse.
   -> A subsequent load of 1024 yields "1","0","2","4".
6. BLANK_LEADING=0, mag=7
   -> HEX_3..HEX_1=1000000, HEX_0=1111000.

Source files
------------

// File: rtl/bcd_display_driver.sv
// -----------------------------------------------------------------------------
// bcd_display_driver
//   Takes the 12-bit product magnitude and sign from the signed multiplier and
//   drives five seven-segment digits. The binary value is converted to BCD with
//   a sequential shift-add-3 (double dabble), one bit per clock. The displays
//   are registered, so they hold the previous result until a conversion ends.
//
// Parameters
//   BLANK_LEADING  : 1 = blank leading zero digits (HEX_0 always shown)
//   SEG_ACTIVE_LOW : 1 = segment lit when bit is 0; 0 = all HEX bits inverted
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   load         in   start pulse, accepted only while idle
//   mag[11:0]    in   unsigned magnitude 0..4095
//   neg          in   sign of the result
//   busy         out  high while a conversion is in progress
//   done         out  one-cycle pulse when the displays update
//   HEX_0..HEX_3 out  decimal digits, units..thousands, {g,f,e,d,c,b,a}
//   HEX_4        out  minus sign digit
// -----------------------------------------------------------------------------
module bcd_display_driver #(
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] mag,
  input  logic        neg,
  output logic        busy,
  output logic        done,
  output logic [6:0]  HEX_0,
  output logic [6:0]  HEX_1,
  output logic [6:0]  HEX_2,
  output logic [6:0]  HEX_3,
  output logic [6:0]  HEX_4
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  localparam logic [6:0] L_AL_BLANK = 7'b1111111;
  localparam logic [6:0] L_AL_ZERO  = 7'b1000000;
  localparam logic [6:0] L_AL_MINUS = 7'b0111111;
  localparam logic [6:0] L_BLANK = SEG_ACTIVE_LOW ? L_AL_BLANK : ~L_AL_BLANK;
  localparam logic [6:0] L_ZERO  = SEG_ACTIVE_LOW ? L_AL_ZERO  : ~L_AL_ZERO;

  // Active-low segment pattern for one decimal digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Apply output polarity to an active-low pattern.
  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic        w_iter;
  logic        w_show;

  logic [11:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_neg;
  logic        r_done;
  logic [6:0]  r_hex0, r_hex1, r_hex2, r_hex3, r_hex4;

  logic [27:0] w_step;
  logic [3:0]  w_d0, w_d1, w_d2, w_d3;
  logic        w_blank1, w_blank2, w_blank3;
  logic        w_minus;

  // Next-state and control
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_iter      = 1'b0;
    w_show      = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_start     = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        busy   = 1'b1;
        w_iter = 1'b1;
        if (r_cnt == 4'd11) w_state_nxt = S_SHOW;
      end
      S_SHOW: begin
        busy        = 1'b1;
        w_show      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One shift-add-3 iteration on the concatenated {bcd, bin} register.
  assign w_step = {add3(r_bcd), r_bin} << 1;

  // Display formatting from the finished BCD value
  assign w_d0 = r_bcd[3:0];
  assign w_d1 = r_bcd[7:4];
  assign w_d2 = r_bcd[11:8];
  assign w_d3 = r_bcd[15:12];
  assign w_blank3 = BLANK_LEADING && (w_d3 == 4'd0);
  assign w_blank2 = w_blank3 && (w_d2 == 4'd0);
  assign w_blank1 = w_blank2 && (w_d1 == 4'd0);
  // Negative zero shows no sign.
  assign w_minus  = r_neg && (r_bcd != 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_hex0  <= L_ZERO;
      r_hex1  <= L_BLANK;
      r_hex2  <= L_BLANK;
      r_hex3  <= L_BLANK;
      r_hex4  <= L_BLANK;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_show;
      if (w_start) begin
        r_bin <= mag;
        r_neg <= neg;
        r_bcd <= '0;
        r_cnt <= '0;
      end
      if (w_iter) begin
        {r_bcd, r_bin} <= w_step;
        r_cnt          <= r_cnt + 4'd1;
      end
      if (w_show) begin
        r_hex0 <= seg_pol(seg_decode(w_d0));
        r_hex1 <= w_blank1 ? L_BLANK : seg_pol(seg_decode(w_d1));
        r_hex2 <= w_blank2 ? L_BLANK : seg_pol(seg_decode(w_d2));
        r_hex3 <= w_blank3 ? L_BLANK : seg_pol(seg_decode(w_d3));
        r_hex4 <= w_minus ? seg_pol(L_AL_MINUS) : L_BLANK;
      end
    end
  end

  assign done  = r_done;
  assign HEX_0 = r_hex0;
  assign HEX_1 = r_hex1;
  assign HEX_2 = r_hex2;
  assign HEX_3 = r_hex3;
  assign HEX_4 = r_hex4;

endmodule
